cdb_writeback: RTL and testbench

CDB_WRITEBACK -- requirements
Module: cdb_writeback

---
 rtl/cdb_writeback_if.sv | 62 ++++++
 rtl/cdb_writeback.sv | 203 ++++++++++++++++++++
 tb/tb_cdb_writeback.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_writeback_if
// Description : Bundle of the issue-grant, unit-result, flush and common data
//               bus (CDB) broadcast signals used by cdb_writeback.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   issue_<u>, issue_<u>_tag : one-cycle issue grant and its destination tag
//                              for unit <u> in {int, ls, mul, div}
//   <u>_result               : unit result, valid in that unit's completion
//                              cycle
//   flush                    : synchronous discard of all in-flight work
//   cdb_valid/tag/data/src   : registered CDB broadcast
//   collision_err            : sticky flag, two or more completions in a cycle
// Modports
//   master : issue/result/flush producer, CDB consumer
//   slave  : the writeback block itself
// ============================================================================
interface cdb_writeback_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);

  logic              issue_int;
  logic              issue_ls;
  logic              issue_mul;
  logic              issue_div;
  logic [TAG_W-1:0]  issue_int_tag;
  logic [TAG_W-1:0]  issue_ls_tag;
  logic [TAG_W-1:0]  issue_mul_tag;
  logic [TAG_W-1:0]  issue_div_tag;
  logic [DATA_W-1:0] int_result;
  logic [DATA_W-1:0] ls_result;
  logic [DATA_W-1:0] mul_result;
  logic [DATA_W-1:0] div_result;
  logic              flush;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0]        cdb_src;
  logic              collision_err;

  modport master (
    output issue_int, issue_ls, issue_mul, issue_div,
    output issue_int_tag, issue_ls_tag, issue_mul_tag, issue_div_tag,
    output int_result, ls_result, mul_result, div_result,
    output flush,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src, collision_err
  );

  modport slave (
    input  issue_int, issue_ls, issue_mul, issue_div,
    input  issue_int_tag, issue_ls_tag, issue_mul_tag, issue_div_tag,
    input  int_result, ls_result, mul_result, div_result,
    input  flush,
    output cdb_valid, cdb_tag, cdb_data, cdb_src, collision_err
  );

endinterface
`default_nettype wire

// File: rtl/cdb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : cdb_writeback
// Description : Result writeback onto a single common data bus. Each of four
//               execution units (int, ls, mul, div) has a fixed latency; a
//               per-unit valid+tag delay line tracks grants until their
//               completion cycle, where the unit result is sampled and the
//               highest-priority completion (div > mul > int > ls) is
//               broadcast one cycle later. Losing completions are dropped
//               and flagged on a sticky collision_err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_MUL_CYC : multiply latency in cycles (>= 2)
//   NUM_DIV_CYC : divide latency in cycles (>= 2)
//   TAG_W       : destination tag width
//   DATA_W      : result width
// Ports
//   clk           : rising-edge clock
//   rst_b         : asynchronous active-low reset
//   bus           : cdb_writeback_if.slave (grants, results, flush, CDB out)
//   collision_cnt : [7:0] saturating count of dropped completions, present
//                   only when CDB_COLLISION_CNT_EN is defined
// Build option
//   CDB_COLLISION_CNT_EN : adds the collision_cnt output and its counter
// ============================================================================
module cdb_writeback #(
  parameter int NUM_MUL_CYC = 4,
  parameter int NUM_DIV_CYC = 6,
  parameter int TAG_W       = 5,
  parameter int DATA_W      = 32
) (
  input  wire            clk,
  input  wire            rst_b,
  cdb_writeback_if.slave bus
`ifdef CDB_COLLISION_CNT_EN
  ,
  output logic [7:0]     collision_cnt
`endif
);

  localparam logic [1:0] c_SRC_INT = 2'd0;
  localparam logic [1:0] c_SRC_LS  = 2'd1;
  localparam logic [1:0] c_SRC_MUL = 2'd2;
  localparam logic [1:0] c_SRC_DIV = 2'd3;

  // --------------------------------------------------------------------------
  // Per-unit delay lines. Stage 0 holds a grant sampled at the previous edge;
  // the last stage is valid in that grant's completion cycle.
  // --------------------------------------------------------------------------
  logic                              int_vld_q, int_vld_d;
  logic [TAG_W-1:0]                  int_tag_q, int_tag_d;
  logic                              ls_vld_q,  ls_vld_d;
  logic [TAG_W-1:0]                  ls_tag_q,  ls_tag_d;
  logic [NUM_MUL_CYC-1:0]            mul_vld_q, mul_vld_d;
  logic [NUM_MUL_CYC-1:0][TAG_W-1:0] mul_tag_q, mul_tag_d;
  logic [NUM_DIV_CYC-1:0]            div_vld_q, div_vld_d;
  logic [NUM_DIV_CYC-1:0][TAG_W-1:0] div_tag_q, div_tag_d;

  // CDB output registers and sticky error
  logic                              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]                  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0]                 cdb_data_q,  cdb_data_d;
  logic [1:0]                        cdb_src_q,   cdb_src_d;
  logic                              collision_err_q, collision_err_d;

  // Completion decode
  logic                              w_int_done;
  logic                              w_ls_done;
  logic                              w_mul_done;
  logic                              w_div_done;
  logic [2:0]                        w_num_done;
  logic                              w_collision;

  // Flush empties every stage and refuses the grants of the same cycle, so
  // nothing issued before or during the flush cycle can ever complete.
  always_comb begin
    int_vld_d = bus.issue_int & ~bus.flush;
    int_tag_d = bus.issue_int_tag;
    ls_vld_d  = bus.issue_ls & ~bus.flush;
    ls_tag_d  = bus.issue_ls_tag;
    mul_vld_d = bus.flush ? '0 : {mul_vld_q[NUM_MUL_CYC-2:0], bus.issue_mul};
    mul_tag_d = {mul_tag_q[NUM_MUL_CYC-2:0], bus.issue_mul_tag};
    div_vld_d = bus.flush ? '0 : {div_vld_q[NUM_DIV_CYC-2:0], bus.issue_div};
    div_tag_d = {div_tag_q[NUM_DIV_CYC-2:0], bus.issue_div_tag};
  end

  assign w_int_done = int_vld_q;
  assign w_ls_done  = ls_vld_q;
  assign w_mul_done = mul_vld_q[NUM_MUL_CYC-1];
  assign w_div_done = div_vld_q[NUM_DIV_CYC-1];

  assign w_num_done = {2'b00, w_int_done} + {2'b00, w_ls_done} +
                      {2'b00, w_mul_done} + {2'b00, w_div_done};

  // Completions that coincide with a flush are discarded outright, so they
  // neither reach the bus nor count as competing for it.
  assign w_collision = ~bus.flush & (w_num_done > 3'd1);

  // --------------------------------------------------------------------------
  // Fixed-priority pick. With no winner the payload registers keep their
  // previous contents and only the valid bit drops.
  // --------------------------------------------------------------------------
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (!bus.flush) begin
      if (w_div_done) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = div_tag_q[NUM_DIV_CYC-1];
        cdb_data_d  = bus.div_result;
        cdb_src_d   = c_SRC_DIV;
      end else if (w_mul_done) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = mul_tag_q[NUM_MUL_CYC-1];
        cdb_data_d  = bus.mul_result;
        cdb_src_d   = c_SRC_MUL;
      end else if (w_int_done) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = int_tag_q;
        cdb_data_d  = bus.int_result;
        cdb_src_d   = c_SRC_INT;
      end else if (w_ls_done) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = ls_tag_q;
        cdb_data_d  = bus.ls_result;
        cdb_src_d   = c_SRC_LS;
      end
    end
  end

  // Sticky: only reset clears it, flush leaves it alone.
  assign collision_err_d = collision_err_q | w_collision;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      int_vld_q       <= 1'b0;
      int_tag_q       <= '0;
      ls_vld_q        <= 1'b0;
      ls_tag_q        <= '0;
      mul_vld_q       <= '0;
      mul_tag_q       <= '0;
      div_vld_q       <= '0;
      div_tag_q       <= '0;
      cdb_valid_q     <= 1'b0;
      cdb_tag_q       <= '0;
      cdb_data_q      <= '0;
      cdb_src_q       <= '0;
      collision_err_q <= 1'b0;
    end else begin
      int_vld_q       <= int_vld_d;
      int_tag_q       <= int_tag_d;
      ls_vld_q        <= ls_vld_d;
      ls_tag_q        <= ls_tag_d;
      mul_vld_q       <= mul_vld_d;
      mul_tag_q       <= mul_tag_d;
      div_vld_q       <= div_vld_d;
      div_tag_q       <= div_tag_d;
      cdb_valid_q     <= cdb_valid_d;
      cdb_tag_q       <= cdb_tag_d;
      cdb_data_q      <= cdb_data_d;
      cdb_src_q       <= cdb_src_d;
      collision_err_q <= collision_err_d;
    end
  end

  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_tag       = cdb_tag_q;
  assign bus.cdb_data      = cdb_data_q;
  assign bus.cdb_src       = cdb_src_q;
  assign bus.collision_err = collision_err_q;

`ifdef CDB_COLLISION_CNT_EN
  // --------------------------------------------------------------------------
  // Dropped-completion counter: adds (completions - 1) in every collision
  // cycle and saturates at 255. The 9-bit sum exposes the overflow.
  // --------------------------------------------------------------------------
  logic [7:0] collision_cnt_q, collision_cnt_d;
  logic [8:0] w_cnt_sum;

  always_comb begin
    w_cnt_sum       = {1'b0, collision_cnt_q} + {6'b0, w_num_done - 3'd1};
    collision_cnt_d = collision_cnt_q;
    if (w_collision) begin
      collision_cnt_d = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      collision_cnt_q <= 8'd0;
    end else begin
      collision_cnt_q <= collision_cnt_d;
    end
  end

  assign collision_cnt = collision_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_writeback
// Description : Scoreboard bench for cdb_writeback. The stimulus process
//               keeps a list of scheduled completions (grant cycle plus unit
//               latency), resolves each cycle's completions by priority and
//               queues the expected broadcasts; a monitor pops and compares
//               whenever the CDB shows valid, and checks hold/idle/reset and
//               the collision state every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_writeback;

  localparam int TAG_W       = 5;
  localparam int DATA_W      = 32;
  localparam int NUM_MUL_CYC = 4;
  localparam int NUM_DIV_CYC = 6;
  localparam int MAXC        = 8192;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  cdb_writeback_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

`ifdef CDB_COLLISION_CNT_EN
  logic [7:0] collision_cnt;
`endif

  cdb_writeback #(
    .NUM_MUL_CYC(NUM_MUL_CYC),
    .NUM_DIV_CYC(NUM_DIV_CYC),
    .TAG_W      (TAG_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
`ifdef CDB_COLLISION_CNT_EN
    ,
    .collision_cnt(collision_cnt)
`endif
  );

  // unit index == cdb_src encoding: 0 int, 1 ls, 2 mul, 3 div
  typedef struct {
    int               done;
    int               unit;
    logic [TAG_W-1:0] tag;
  } pend_t;

  typedef struct {
    int                cyc;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } exp_t;

  pend_t pend[$];
  exp_t  sb[$];
  int    cyc      = 0;
  int    n_checks = 0;
  int    n_err    = 0;
  bit       exp_err [MAXC];
  bit [7:0] exp_cnt [MAXC];
  bit    m_err = 1'b0;
  int    m_cnt = 0;
  bit                fr_en  = 1'b0;
  logic [DATA_W-1:0] fr_val = '0;

  function automatic int lat(input int u);
    case (u)
      0, 1:    return 1;
      2:       return NUM_MUL_CYC;
      default: return NUM_DIV_CYC;
    endcase
  endfunction

  function automatic int rank(input int u);
    case (u)
      3:       return 3;
      2:       return 2;
      0:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model.
  task automatic step(input bit [3:0] g, input logic [TAG_W-1:0] t0, t1, t2, t3,
                      input bit fl, input bit rb);
    logic [DATA_W-1:0] r  [4];
    logic [TAG_W-1:0]  tg [4];
    pend_t             keep[$];
    int                n, best, bu;
    logic [TAG_W-1:0]  bt;
    tg[0] = t0; tg[1] = t1; tg[2] = t2; tg[3] = t3;
    for (int u = 0; u < 4; u++) r[u] = $urandom;
    if (fr_en) r[0] = fr_val;
    fr_en = 1'b0;
    bus.issue_int     = g[0];
    bus.issue_ls      = g[1];
    bus.issue_mul     = g[2];
    bus.issue_div     = g[3];
    bus.issue_int_tag = t0;
    bus.issue_ls_tag  = t1;
    bus.issue_mul_tag = t2;
    bus.issue_div_tag = t3;
    bus.int_result    = r[0];
    bus.ls_result     = r[1];
    bus.mul_result    = r[2];
    bus.div_result    = r[3];
    bus.flush         = fl;
    rst_b             = rb;
    if (!rb) begin
      pend.delete();
      sb.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else if (fl) begin
      pend.delete();
    end else begin
      n = 0; best = -1; bu = 0; bt = '0;
      foreach (pend[i]) begin
        if (pend[i].done == cyc) begin
          n++;
          if (rank(pend[i].unit) > best) begin
            best = rank(pend[i].unit);
            bu   = pend[i].unit;
            bt   = pend[i].tag;
          end
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
      if (n > 0) sb.push_back('{cyc + 1, bt, r[bu], 2'(bu)});
      if (n > 1) begin
        m_err = 1'b1;
        m_cnt = (m_cnt + n - 1 > 255) ? 255 : m_cnt + n - 1;
      end
      for (int u = 0; u < 4; u++)
        if (g[u]) pend.push_back('{cyc + lat(u), u, tg[u]});
    end
    if (cyc + 1 < MAXC) begin
      exp_err[cyc+1] = m_err;
      exp_cnt[cyc+1] = 8'(m_cnt);
    end
    if (!rb) begin
      exp_err[cyc] = 1'b0;
      exp_cnt[cyc] = 8'd0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, '0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic [TAG_W-1:0]  l_tag;
    logic [DATA_W-1:0] l_data;
    logic [1:0]        l_src;
    exp_t              e;
    l_tag = '0; l_data = '0; l_src = '0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missed_broadcast", 64'(cyc), 64'(e.cyc));
      end
      if (!rst_b) begin
        chk("rst_valid", bus.cdb_valid, 0);
        chk("rst_tag",   bus.cdb_tag,   0);
        chk("rst_data",  bus.cdb_data,  0);
        chk("rst_src",   bus.cdb_src,   0);
        l_tag = '0; l_data = '0; l_src = '0;
      end else if (bus.cdb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_broadcast cycle %0d: got cdb_valid=1 tag 0x%0h expected cdb_valid=0",
                   cyc, bus.cdb_tag);
        end else begin
          e = sb.pop_front();
          chk("bcast_cycle", 64'(cyc), 64'(e.cyc));
          chk("bcast_tag",   bus.cdb_tag,  e.tag);
          chk("bcast_data",  bus.cdb_data, e.data);
          chk("bcast_src",   bus.cdb_src,  e.src);
          l_tag = e.tag; l_data = e.data; l_src = e.src;
        end
      end else begin
        chk("idle_valid", bus.cdb_valid, 0);
        chk("hold_tag",   bus.cdb_tag,   l_tag);
        chk("hold_data",  bus.cdb_data,  l_data);
        chk("hold_src",   bus.cdb_src,   l_src);
      end
      chk("collision_err", bus.collision_err, exp_err[cyc]);
`ifdef CDB_COLLISION_CNT_EN
      chk("collision_cnt", collision_cnt, exp_cnt[cyc]);
`endif
    end
  end

  initial begin
    bit [3:0]         g;
    logic [TAG_W-1:0] t [4];
    bit               fl, rb;
    rst_b = 1'b0;
    rst_cycles(3);
    idle(2);

    // int grant tag 3, result 0xA5 in completion cycle, broadcast two later
    step(4'b0001, 5'd3, '0, '0, '0, 1'b0, 1'b1);
    fr_en  = 1'b1;
    fr_val = 32'h0000_00A5;
    idle(4);

    // div tag 7 and mul tag 9 both complete in the same cycle
    step(4'b1000, '0, '0, '0, 5'd7, 1'b0, 1'b1);
    idle(1);
    step(4'b0100, '0, '0, 5'd9, '0, 1'b0, 1'b1);
    idle(8);
    rst_cycles(2);
    idle(1);

    // back-to-back multiplies, tags 0..9
    for (int i = 0; i < 10; i++) step(4'b0100, '0, '0, 5'(i), '0, 1'b0, 1'b1);
    idle(8);

    // flush kills an in-flight divide, the next int grant proceeds
    step(4'b1000, '0, '0, '0, 5'd4, 1'b0, 1'b1);
    idle(2);
    step(4'b0000, '0, '0, '0, '0, 1'b1, 1'b1);
    step(4'b0001, 5'd11, '0, '0, '0, 1'b0, 1'b1);
    idle(10);

    // reset in the middle of a multiply
    step(4'b0100, '0, '0, 5'd2, '0, 1'b0, 1'b1);
    idle(1);
    rst_cycles(1);
    idle(8);

    // 300 int/ls collisions drive the counter into saturation
    for (int i = 0; i < 300; i++)
      step(4'b0011, 5'($urandom), 5'($urandom), '0, '0, 1'b0, 1'b1);
    idle(5);
    rst_cycles(2);
    idle(1);

    // randomized traffic with occasional flush and reset
    for (int k = 0; k < 2000; k++) begin
      for (int u = 0; u < 4; u++) begin
        g[u] = ($urandom_range(0, 99) < 35);
        t[u] = 5'($urandom);
      end
      fl = ($urandom_range(0, 99) < 3);
      rb = ($urandom_range(0, 299) != 0);
      step(g, t[0], t[1], t[2], t[3], fl, rb);
    end
    idle(10);
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
